branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
ID-stage branch resolution block, directly downstream of the ID-stage equality/sign comparator. Drives the comparator's mode select, consumes its Zero/Sign flags, and decides taken/not-taken. Computes the branch target and issues a registered one-cycle PC redirect plus IF/ID flush. Stalls the front end while forwarded operands are not yet valid.

Parameters:
WIDTH, 32, PC/offset datapath width
MAX_WAIT, 3, maximum consecutive operand-wait cycles before the sticky Error flag sets
WAIT_CNT_W, 2, width of the wait counter; must satisfy 2^WAIT_CNT_W > MAX_WAIT

Ports:
Clk  in  1  rising-edge clock
Rst  in  1  asynchronous, active-low reset
BranchValid  in  1  branch instruction present in ID
BranchOp  in  3  000 none, 001 BEQ, 010 BNE, 011 BLTZ, 100 BGEZ, 101 BLEZ, 110 BGTZ, 111 reserved (never taken)
OperandsReady  in  1  hazard unit: forwarded rs/rt values valid this cycle
Zero  in  1  comparator result == 0
Sign  in  1  comparator result[31]
PCPlus4  in  WIDTH  PC+4 of branch in ID
Offset  in  WIDTH  sign-extended immediate (word offset)
BranchCtrl  out  1  comparator mode: 1 for BEQ/BNE (A-B), else 0 (A vs zero); combinational from BranchOp
Stall  out  1  hold PC and IF/ID
Redirect  out  1  one-cycle pulse: load RedirectPC into PC
RedirectPC  out  WIDTH  branch target
Flush  out  1  one-cycle pulse: zero IF/ID
Error  out  1  sticky: wait exceeded MAX_WAIT
BranchCount, TakenCount, StallCycles  out  32 each  statistics (see Optional Feature)

Behaviour:
- Reset (Rst=0, async): state IDLE; Redirect, Flush, Error = 0; RedirectPC = 0; wait counter = 0; statistics counters = 0.
- Taken conditions: BEQ Zero; BNE !Zero; BLTZ Sign; BGEZ !Sign; BLEZ Sign|Zero; BGTZ !Sign&!Zero; 000/111 never taken.
- Target = PCPlus4 + (Offset << 2), truncated to WIDTH (wrap-around permitted, no flag).
- FSM states: IDLE, WAIT, REDIRECT.
- IDLE:
  - BranchValid & op≠000 & OperandsReady: evaluate. Taken → register RedirectPC, go REDIRECT. Not taken → stay IDLE, no pulse.
  - BranchValid & op≠000 & !OperandsReady: Stall=1 combinationally (same cycle), counter ← 1, go WAIT.
  - Otherwise: no action.
- WAIT:
  - Stall=1 unless OperandsReady.
  - OperandsReady: evaluate as in IDLE; go REDIRECT if taken, else IDLE; counter ← 0.
  - !OperandsReady: counter increments, saturating. When counter reaches MAX_WAIT, Error ← 1 (sticky until reset); remain in WAIT.
  - BranchValid dropping in WAIT (external squash): return to IDLE, no redirect.
- REDIRECT (exactly one cycle): Redirect=1, Flush=1, RedirectPC holds the target. BranchValid is ignored (the ID instruction is being flushed). Next state IDLE.
- Latency: a taken branch is decided in cycle N; Redirect/Flush are high in cycle N+1. Back-to-back branches resolve no more often than every 2 cycles.
- Stall and Redirect are never simultaneously 1.
- Reset mid-WAIT or mid-REDIRECT: immediately returns to IDLE; pending pulse is dropped.

Optional Feature:
BRANCH_STATS_EN
- Defined:
  - BranchCount increments on each evaluation.
  - TakenCount increments on each taken decision.
  - StallCycles increments on each cycle with Stall=1.
  - All three wrap at 2^32.
- Undefined: counters are not instantiated; the three ports are tied to 0.

Decomposition:
- Shared package branch_pkg:
  - BranchOp encodings (BR_NONE, BR_BEQ, … BR_GTZ).
  - FSM state encodings (ST_IDLE, ST_WAIT, ST_REDIRECT).
  - BRANCH_OP_W = 3.
- Sub-module branch_cond_eval: combinational (BranchOp, Zero, Sign) → Taken and BranchCtrl. It is reused by the verification scoreboard.

Test Plan:
- BEQ, OperandsReady=1, Zero=1, PCPlus4=0x00400004, Offset=0x3 → next cycle Redirect=Flush=1, RedirectPC=0x00400010; following cycle both 0.
- BGTZ, Zero=0, Sign=1 → not taken; no Redirect/Flush; BranchCtrl=0; state IDLE.
- BNE, OperandsReady low for 2 cycles then high with Zero=0 → Stall=1 for 2 cycles, Redirect pulse in the cycle after ready; Error=0.
- OperandsReady held low for 5 cycles, MAX_WAIT=3 → Error=1 from cycle 3, stays 1 after release until Rst=0.
- Offset=0xFFFFFFFF, PCPlus4=0x00000000 → RedirectPC=0xFFFFFFFC (wrap); BranchValid asserted during REDIRECT is ignored.
- Rst asserted in REDIRECT cycle → Redirect/Flush drop immediately. With BRANCH_STATS_EN: 3 branches (2 taken, 1 stall cycle) → BranchCount=3, TakenCount=2, StallCycles=1.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// branch_pkg: branch opcode and resolver FSM state encodings shared by the resolver and its bench
package branch_pkg;
  localparam int BRANCH_OP_W = 3;
  typedef enum logic [BRANCH_OP_W-1:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_LTZ  = 3'b011,
    BR_GEZ  = 3'b100,
    BR_LEZ  = 3'b101,
    BR_GTZ  = 3'b110,
    BR_RSVD = 3'b111
  } branch_op_e;
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_REDIRECT = 2'd2
  } branch_state_e;
endpackage

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: ID-stage branch bus between pipeline/comparator (master) and resolver (slave)
interface branch_resolve_unit_if import branch_pkg::*; #(parameter int WIDTH = 32);
  logic                   BranchValid;
  logic [BRANCH_OP_W-1:0] BranchOp;
  logic                   OperandsReady;
  logic                   Zero;
  logic                   Sign;
  logic [WIDTH-1:0]       PCPlus4;
  logic [WIDTH-1:0]       Offset;
  logic                   BranchCtrl;
  logic                   Stall;
  logic                   Redirect;
  logic [WIDTH-1:0]       RedirectPC;
  logic                   Flush;
  logic                   Error;
  logic [31:0]            BranchCount;
  logic [31:0]            TakenCount;
  logic [31:0]            StallCycles;
  modport master (
    output BranchValid, BranchOp, OperandsReady, Zero, Sign, PCPlus4, Offset,
    input  BranchCtrl, Stall, Redirect, RedirectPC, Flush, Error, BranchCount, TakenCount, StallCycles
  );
  modport slave (
    input  BranchValid, BranchOp, OperandsReady, Zero, Sign, PCPlus4, Offset,
    output BranchCtrl, Stall, Redirect, RedirectPC, Flush, Error, BranchCount, TakenCount, StallCycles
  );
endinterface

// File: rtl/branch_resolve_unit_cond_eval.sv
// branch_cond_eval: maps opcode plus comparator Zero/Sign flags to taken decision and comparator mode
module branch_cond_eval import branch_pkg::*; (
  input  logic [BRANCH_OP_W-1:0] op_i,
  input  logic                   zero_i,
  input  logic                   sign_i,
  output logic                   taken_o,
  output logic                   ctrl_o
);
  branch_op_e op;
  assign op = branch_op_e'(op_i);
  // BEQ/BNE compare A-B; the zero-relative branches compare A against zero
  always_comb begin
    ctrl_o  = op == BR_BEQ || op == BR_BNE;
    taken_o = op == BR_BEQ ? zero_i :
              op == BR_BNE ? !zero_i :
              op == BR_LTZ ? sign_i :
              op == BR_GEZ ? !sign_i :
              op == BR_LEZ ? sign_i || zero_i :
              op == BR_GTZ ? !sign_i && !zero_i : 1'b0;
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: ID-stage branch resolve, registered redirect/flush pulse, operand-wait stall; BRANCH_STATS_EN adds statistics counters
module branch_resolve_unit import branch_pkg::*; #(
  parameter int WIDTH      = 32,
  parameter int MAX_WAIT   = 3,
  parameter int WAIT_CNT_W = 2
) (
  input logic Clk,
  input logic Rst,
  branch_resolve_unit_if.slave bus
);
  localparam logic [WAIT_CNT_W-1:0] MAXW = WAIT_CNT_W'(MAX_WAIT);
  branch_state_e         state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]      rpc_q, rpc_d;
  logic                  err_q, err_d;
  logic                  taken, ctrl, active, eval, stall;
  logic [WIDTH-1:0]      target;
  branch_cond_eval u_cond (
    .op_i   (bus.BranchOp),
    .zero_i (bus.Zero),
    .sign_i (bus.Sign),
    .taken_o(taken),
    .ctrl_o (ctrl)
  );
  assign active = bus.BranchValid && bus.BranchOp != BR_NONE;
  assign target = bus.PCPlus4 + (bus.Offset << 2);
  // next state, wait counter and target capture; the REDIRECT cycle ignores the ID slot since it is being flushed
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rpc_d   = rpc_q;
    stall   = 1'b0;
    eval    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        eval    = active && bus.OperandsReady;
        stall   = active && !bus.OperandsReady;
        cnt_d   = stall ? WAIT_CNT_W'(1) : cnt_q;
        state_d = stall ? ST_WAIT : ST_IDLE;
      end
      ST_WAIT: begin
        stall   = !bus.OperandsReady;
        eval    = bus.BranchValid && bus.OperandsReady;
        cnt_d   = !bus.BranchValid || bus.OperandsReady ? '0 : cnt_q == '1 ? cnt_q : cnt_q + 1'b1;
        state_d = bus.BranchValid && !bus.OperandsReady ? ST_WAIT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (eval && taken) begin
      state_d = ST_REDIRECT;
      rpc_d   = target;
    end
    err_d = err_q || cnt_d >= MAXW;
  end
  // FSM, wait counter, target and sticky error registers
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rpc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rpc_q   <= rpc_d;
      err_q   <= err_d;
    end
  end
  assign bus.BranchCtrl = ctrl;
  assign bus.Stall      = stall;
  assign bus.Redirect   = state_q == ST_REDIRECT;
  assign bus.Flush      = state_q == ST_REDIRECT;
  assign bus.RedirectPC = rpc_q;
  assign bus.Error      = err_q;
`ifdef BRANCH_STATS_EN
  logic [31:0] bc_q, tc_q, sc_q;
  // free-running statistics, wrapping at 2^32
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      bc_q <= '0;
      tc_q <= '0;
      sc_q <= '0;
    end else begin
      bc_q <= bc_q + 32'(eval);
      tc_q <= tc_q + 32'(eval && taken);
      sc_q <= sc_q + 32'(stall);
    end
  end
  assign bus.BranchCount = bc_q;
  assign bus.TakenCount  = tc_q;
  assign bus.StallCycles = sc_q;
`else
  assign bus.BranchCount = '0;
  assign bus.TakenCount  = '0;
  assign bus.StallCycles = '0;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: directed vectors with a cycle-level behavioural model and literal spot checks
module tb_branch_resolve_unit;
  localparam int MAX_WAIT = 3;
  localparam int CNT_MAX  = 3;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  branch_resolve_unit_if bus ();
  branch_resolve_unit dut (.Clk(clk), .Rst(rst_n), .bus(bus));
  int total = 0;
  int bad   = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic bit tk(input logic [2:0] op, input logic z, input logic s);
    case (op)
      3'd1: return z;
      3'd2: return !z;
      3'd3: return s;
      3'd4: return !s;
      3'd5: return s || z;
      3'd6: return !s && !z;
      default: return 1'b0;
    endcase
  endfunction
  logic        m_redir = 0, m_waiting = 0, m_err = 0;
  logic [31:0] m_pc = 0, m_bc = 0, m_tc = 0, m_sc = 0;
  int          m_wait = 0;
  logic        n_redir = 0, n_waiting = 0, n_err = 0;
  logic [31:0] n_pc = 0, n_bc = 0, n_tc = 0, n_sc = 0;
  int          n_wait = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_redir <= 0; m_waiting <= 0; m_err <= 0; m_pc <= 0;
      m_bc <= 0; m_tc <= 0; m_sc <= 0; m_wait <= 0;
    end else begin
      m_redir <= n_redir; m_waiting <= n_waiting; m_err <= n_err; m_pc <= n_pc;
      m_bc <= n_bc; m_tc <= n_tc; m_sc <= n_sc; m_wait <= n_wait;
    end
  end
  always @(negedge clk) begin
    logic es, dec;
    if (rst_n) begin
      es = !m_redir && (m_waiting ? !bus.OperandsReady
                                  : bus.BranchValid && bus.BranchOp != 0 && !bus.OperandsReady);
      chk("stall", bus.Stall, es);
      chk("ctrl", bus.BranchCtrl, bus.BranchOp == 1 || bus.BranchOp == 2);
      chk("redirect", bus.Redirect, m_redir);
      chk("flush", bus.Flush, m_redir);
      chk("rpc", bus.RedirectPC, m_pc);
      chk("error", bus.Error, m_err);
`ifdef BRANCH_STATS_EN
      chk("bcount", bus.BranchCount, m_bc);
      chk("tcount", bus.TakenCount, m_tc);
      chk("scycles", bus.StallCycles, m_sc);
`else
      chk("bcount", bus.BranchCount, 0);
      chk("tcount", bus.TakenCount, 0);
      chk("scycles", bus.StallCycles, 0);
`endif
      n_redir = 0; n_pc = m_pc; n_waiting = m_waiting; n_wait = m_wait; n_err = m_err;
      n_bc = m_bc; n_tc = m_tc; n_sc = m_sc; dec = 0;
      if (!m_redir) begin
        if (m_waiting) begin
          if (!bus.BranchValid) begin n_waiting = 0; n_wait = 0; end
          else if (bus.OperandsReady) dec = 1;
          else n_wait = m_wait < CNT_MAX ? m_wait + 1 : CNT_MAX;
        end else if (bus.BranchValid && bus.BranchOp != 0) begin
          if (bus.OperandsReady) dec = 1;
          else begin n_waiting = 1; n_wait = 1; end
        end
      end
      if (dec) begin
        n_bc = m_bc + 1; n_waiting = 0; n_wait = 0;
        if (tk(bus.BranchOp, bus.Zero, bus.Sign)) begin
          n_tc = m_tc + 1; n_redir = 1; n_pc = bus.PCPlus4 + (bus.Offset << 2);
        end
      end
      if (es) n_sc = m_sc + 1;
      if (n_wait >= MAX_WAIT) n_err = 1;
    end
  end
  task automatic step(input logic v, input logic [2:0] op, input logic rdy, input logic z, input logic s,
                      input logic [31:0] pc4, input logic [31:0] off);
    @(posedge clk);
    #1;
    bus.BranchValid = v; bus.BranchOp = op; bus.OperandsReady = rdy;
    bus.Zero = z; bus.Sign = s; bus.PCPlus4 = pc4; bus.Offset = off;
  endtask
  task automatic idle();
    step(0, 3'd0, 1, 0, 0, 0, 0);
  endtask
  initial begin
    bus.BranchValid = 0; bus.BranchOp = 0; bus.OperandsReady = 1;
    bus.Zero = 0; bus.Sign = 0; bus.PCPlus4 = 0; bus.Offset = 0;
    #1 rst_n = 0;
    #1;
    chk("rst_redirect", bus.Redirect, 0);
    chk("rst_flush", bus.Flush, 0);
    chk("rst_error", bus.Error, 0);
    chk("rst_rpc", bus.RedirectPC, 0);
    chk("rst_bcount", bus.BranchCount, 0);
    @(posedge clk); #1 rst_n = 1;
    step(1, 3'd1, 1, 1, 0, 32'h00400004, 32'h3);
    idle(); #1;
    chk("beq_redirect", bus.Redirect, 1);
    chk("beq_flush", bus.Flush, 1);
    chk("beq_rpc", bus.RedirectPC, 32'h00400010);
    idle(); #1;
    chk("beq_redirect_end", bus.Redirect, 0);
    chk("beq_flush_end", bus.Flush, 0);
    step(1, 3'd6, 1, 0, 1, 32'h100, 32'h8); #1;
    chk("bgtz_ctrl", bus.BranchCtrl, 0);
    idle(); #1;
    chk("bgtz_no_redirect", bus.Redirect, 0);
    step(1, 3'd2, 0, 0, 0, 32'h200, 32'h10); #1;
    chk("bne_stall1", bus.Stall, 1);
    chk("bne_ctrl", bus.BranchCtrl, 1);
    step(1, 3'd2, 0, 0, 0, 32'h200, 32'h10); #1;
    chk("bne_stall2", bus.Stall, 1);
    step(1, 3'd2, 1, 0, 0, 32'h200, 32'h10); #1;
    chk("bne_stall_rel", bus.Stall, 0);
    idle(); #1;
    chk("bne_redirect", bus.Redirect, 1);
    chk("bne_rpc", bus.RedirectPC, 32'h240);
    chk("bne_error", bus.Error, 0);
    idle();
    for (int i = 0; i < 5; i++) begin
      step(1, 3'd5, 0, 0, 0, 32'h300, 32'h1); #1;
      chk("wait_error", bus.Error, i >= 3);
    end
    step(1, 3'd5, 1, 0, 0, 32'h300, 32'h1);
    idle(); #1;
    chk("error_sticky", bus.Error, 1);
    chk("blez_not_taken", bus.Redirect, 0);
    step(1, 3'd1, 1, 1, 0, 32'h0, 32'hFFFFFFFF);
    step(1, 3'd1, 1, 1, 0, 32'h100, 32'h1); #1;
    chk("wrap_rpc", bus.RedirectPC, 32'hFFFFFFFC);
    chk("wrap_redirect", bus.Redirect, 1);
    idle(); #1;
    chk("ignored_redirect", bus.Redirect, 0);
    chk("ignored_rpc", bus.RedirectPC, 32'hFFFFFFFC);
    step(1, 3'd2, 0, 0, 0, 32'h400, 32'h2);
    step(0, 3'd2, 1, 0, 0, 32'h400, 32'h2);
    idle(); #1;
    chk("squash_redirect", bus.Redirect, 0);
    step(1, 3'd7, 1, 1, 1, 32'h500, 32'h2);
    idle(); #1;
    chk("rsvd_redirect", bus.Redirect, 0);
    step(1, 3'd1, 1, 1, 0, 32'h1000, 32'h4);
    idle(); #1;
    chk("pre_rst_redirect", bus.Redirect, 1);
    #1 rst_n = 0;
    #1;
    chk("rst_mid_redirect", bus.Redirect, 0);
    chk("rst_mid_flush", bus.Flush, 0);
    chk("rst_mid_error", bus.Error, 0);
    chk("rst_mid_rpc", bus.RedirectPC, 0);
    @(posedge clk); #1 rst_n = 1;
    step(1, 3'd1, 1, 1, 0, 32'h10, 32'h1);
    idle();
    step(1, 3'd3, 0, 0, 1, 32'h20, 32'h2);
    step(1, 3'd3, 1, 0, 1, 32'h20, 32'h2);
    idle();
    step(1, 3'd4, 1, 0, 1, 32'h30, 32'h3);
    idle(); #1;
`ifdef BRANCH_STATS_EN
    chk("stats_bcount", bus.BranchCount, 3);
    chk("stats_tcount", bus.TakenCount, 2);
    chk("stats_scycles", bus.StallCycles, 1);
`else
    chk("stats_bcount", bus.BranchCount, 0);
    chk("stats_tcount", bus.TakenCount, 0);
    chk("stats_scycles", bus.StallCycles, 0);
`endif
    idle();
    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
